// File: rtl/demux1_8_seq.sv
// ============================================================================
// demux1_8_seq
// ----------------------------------------------------------------------------
// Registered 1-to-8 demultiplexer / deserializer. This block distributes data
// the way the 8:1 select mux gathers it. A single serial bit is steered into
// one of eight registered output lanes. Lanes are chosen either by an explicit
// 3-bit select (addressed mode) or by an internal scan index that walks all
// eight lanes and collects one byte (auto-scan mode).
//
// Configuration macro:
//   SCAN_MSB_FIRST_EN - when defined, a scan starts at lane 7 and walks down to
//                       lane 0. The idle/reset scan index is then 7. When the
//                       macro is undefined, a scan runs from lane 0 up to
//                       lane 7 and the idle/reset index is 0. Addressed mode
//                       behaves the same in both builds.
//
// Parameters:
//   RESET_VAL  value loaded into the output lanes by reset
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous, active-high reset
//   e         in   1  global enable; low freezes all state
//   in        in   1  serial data bit
//   in_valid  in   1  qualifier for the data bit
//   sel       in   3  lane index used in addressed mode
//   start     in   1  one-cycle request to begin an 8-bit scan
//   o         out  8  registered lane outputs
//   stb       out  8  one-hot strobe of the lane written on the last edge
//   busy      out  1  high while a scan is in progress
//   done      out  1  one-cycle pulse after a scan's final write
//   idx       out  3  current scan lane index
// ============================================================================
module demux1_8_seq #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e,
    input  logic       in,
    input  logic       in_valid,
    input  logic [2:0] sel,
    input  logic       start,
    output logic [7:0] o,
    output logic [7:0] stb,
    output logic       busy,
    output logic       done,
    output logic [2:0] idx
);

`ifdef SCAN_MSB_FIRST_EN
    localparam logic [2:0] SCAN_FIRST = 3'd7;
    localparam logic [2:0] SCAN_LAST  = 3'd0;
`else
    localparam logic [2:0] SCAN_FIRST = 3'd0;
    localparam logic [2:0] SCAN_LAST  = 3'd7;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       wr_en;
    logic [2:0] wr_lane;
    logic [7:0] o_next;
    logic [7:0] stb_next;
    logic [2:0] idx_next;
    logic       busy_next;
    logic       done_next;

    // Step the scan index one lane in the configured direction. The 3-bit
    // arithmetic wraps from the last lane back to the first lane.
    function automatic logic [2:0] step_idx(input logic [2:0] cur);
`ifdef SCAN_MSB_FIRST_EN
        return cur - 3'd1;
`else
        return cur + 3'd1;
`endif
    endfunction

    // State register. Reset returns to IDLE from any state, so a partial
    // byte is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. When the enable is low the state does not move,
    // and a pending DONE cycle is held until the enable returns.
    always_comb begin
        state_next = state;
        if (e) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = SCAN;
                    end
                end
                SCAN: begin
                    if (in_valid && (idx == SCAN_LAST)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output logic. This process computes the next value of every
    // registered output. In IDLE, start takes priority over an addressed
    // write. In SCAN, sel and start are ignored and only the scan index
    // picks the lane. done and stb default to zero, so they are pulses.
    // A disabled edge clears them and holds everything else.
    always_comb begin
        wr_en     = 1'b0;
        wr_lane   = sel;
        idx_next  = idx;
        busy_next = busy;
        done_next = 1'b0;
        stb_next  = 8'h00;
        o_next    = o;

        if (e) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx_next  = SCAN_FIRST;
                        busy_next = 1'b1;
                    end else if (in_valid) begin
                        wr_en   = 1'b1;
                        wr_lane = sel;
                    end
                end
                SCAN: begin
                    if (in_valid) begin
                        wr_en    = 1'b1;
                        wr_lane  = idx;
                        idx_next = step_idx(idx);
                        if (idx == SCAN_LAST) begin
                            busy_next = 1'b0;
                            done_next = 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_next = 1'b0;
                end
                default: begin
                    idx_next  = SCAN_FIRST;
                    busy_next = 1'b0;
                end
            endcase
        end

        if (wr_en) begin
            o_next[wr_lane]   = in;
            stb_next[wr_lane] = 1'b1;
        end
    end

    // Output registers. These hold the lane data, the strobe, the status
    // flags, and the scan index. The strobe is built from one lane index,
    // so it can never have more than one bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            o    <= RESET_VAL;
            stb  <= 8'h00;
            busy <= 1'b0;
            done <= 1'b0;
            idx  <= SCAN_FIRST;
        end else begin
            o    <= o_next;
            stb  <= stb_next;
            busy <= busy_next;
            done <= done_next;
            idx  <= idx_next;
        end
    end

endmodule

// File: tb/tb_demux1_8_seq.sv
// ============================================================================
// tb_demux1_8_seq
// ----------------------------------------------------------------------------
// Bench for demux1_8_seq. A behavioural model tracks what the lanes and flags
// should be: whether a scan is running and how many bits it has taken. Every
// output is compared to the model after each clock edge. Directed steps also
// compare against fixed expected values.
// Honours SCAN_MSB_FIRST_EN in the same way as the design.
// ============================================================================
module tb_demux1_8_seq;

    localparam logic [7:0] RESET_VAL = 8'h00;

`ifdef SCAN_MSB_FIRST_EN
    localparam logic [7:0] SCAN_BYTE = 8'hB2;
    localparam bit         MSB_FIRST = 1'b1;
`else
    localparam logic [7:0] SCAN_BYTE = 8'h4D;
    localparam bit         MSB_FIRST = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       e;
    logic       din;
    logic       in_valid;
    logic [2:0] sel;
    logic       start;
    logic [7:0] o;
    logic [7:0] stb;
    logic       busy;
    logic       done;
    logic [2:0] idx;

    int n_vectors;
    int n_miscompares;

    // Reference model state
    logic [7:0] m_o;
    logic [7:0] m_stb;
    bit         m_scanning;
    bit         m_in_done;
    bit         m_done;
    int         m_taken;

    demux1_8_seq #(
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .e       (e),
        .in      (din),
        .in_valid(in_valid),
        .sel     (sel),
        .start   (start),
        .o       (o),
        .stb     (stb),
        .busy    (busy),
        .done    (done),
        .idx     (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return the lane that receives the n-th bit of a scan (n counts from 0).
    function automatic int laneOf(input int n);
        return MSB_FIRST ? (7 - n) : n;
    endfunction

    // Advance the model by one clock edge, using the inputs that were
    // presented before that edge.
    task automatic modelStep(input bit r, input bit en, input bit d,
                             input bit v, input int s, input bit st);
        int lane;
        if (r) begin
            m_o        = RESET_VAL;
            m_stb      = 8'h00;
            m_scanning = 1'b0;
            m_in_done  = 1'b0;
            m_done     = 1'b0;
            m_taken    = 0;
            return;
        end
        m_stb  = 8'h00;
        m_done = 1'b0;
        if (!en) return;
        if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (m_scanning) begin
            if (v) begin
                lane        = laneOf(m_taken);
                m_o[lane]   = d;
                m_stb[lane] = 1'b1;
                m_taken     = m_taken + 1;
                if (m_taken == 8) begin
                    m_scanning = 1'b0;
                    m_in_done  = 1'b1;
                    m_done     = 1'b1;
                    m_taken    = 0;
                end
            end
        end else if (st) begin
            m_scanning = 1'b1;
            m_taken    = 0;
        end else if (v) begin
            m_o[s]   = d;
            m_stb[s] = 1'b1;
        end
    endtask

    // Compare one observed value with its expected value.
    task automatic checkField(input string tag, input logic [7:0] obs,
                              input logic [7:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model.
    task automatic checkOutput();
        checkField("o",    o,             m_o);
        checkField("stb",  stb,           m_stb);
        checkField("busy", {7'd0, busy},  {7'd0, m_scanning});
        checkField("done", {7'd0, done},  {7'd0, m_done});
        checkField("idx",  {5'd0, idx},   8'(laneOf(m_taken)));
        checkField("stb_onehot0", {7'd0, $onehot0(stb)}, 8'd1);
    endtask

    // Drive one cycle of inputs, clock them in, update the model, and
    // check the outputs just after the edge.
    task automatic applyStimulus(input bit r, input bit en, input bit d,
                                 input bit v, input logic [2:0] s,
                                 input bit st);
        reset    = r;
        e        = en;
        din      = d;
        in_valid = v;
        sel      = s;
        start    = st;
        @(posedge clk);
        modelStep(r, en, d, v, int'(s), st);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [7:0] bits;
        logic       keep;
        n_vectors     = 0;
        n_miscompares = 0;
        reset = 1'b1; e = 1'b0; din = 1'b0; in_valid = 1'b0; sel = 3'd0; start = 1'b0;
        m_o = RESET_VAL; m_stb = 8'h00; m_scanning = 1'b0; m_in_done = 1'b0;
        m_done = 1'b0; m_taken = 0;
        bits = 8'b0100_1101;
        #2;

        $display("[TB] reset for two cycles");
        applyStimulus(1, 0, 0, 0, 3'd0, 0);
        applyStimulus(1, 0, 0, 0, 3'd0, 0);
        checkField("reset_o", o, 8'h00);
        checkField("reset_idx", {5'd0, idx}, MSB_FIRST ? 8'd7 : 8'd0);

        $display("[TB] addressed writes");
        applyStimulus(0, 1, 1, 1, 3'd5, 0);
        checkField("addr_o_set", o, 8'h20);
        checkField("addr_stb", stb, 8'h20);
        applyStimulus(0, 1, 0, 1, 3'd5, 0);
        checkField("addr_o_clr", o, 8'h00);
        applyStimulus(0, 0, 1, 1, 3'd3, 0);
        checkField("addr_disabled", o, 8'h00);

        $display("[TB] clean auto-scan");
        applyStimulus(0, 1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, bits[i], 1, 3'($urandom_range(7)), 0);
            if (i < 7) checkField("scan_busy", {7'd0, busy}, 8'd1);
        end
        checkField("scan_byte", o, SCAN_BYTE);
        checkField("scan_done", {7'd0, done}, 8'd1);
        applyStimulus(0, 1, 0, 0, 3'd0, 0);
        checkField("scan_done_drop", {7'd0, done}, 8'd0);

        $display("[TB] scan with stalls, disables and a late start");
        applyStimulus(0, 1, 0, 1, 3'd0, 0);
        applyStimulus(0, 1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, bits[i], 1, 3'($urandom_range(7)), i == 3);
            if (i == 2) begin
                for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 3'd1, 0);
            end
            if (i == 5) begin
                for (int k = 0; k < 2; k++) applyStimulus(0, 0, 1, 1, 3'd1, 0);
            end
        end
        checkField("stall_byte", o, SCAN_BYTE);
        applyStimulus(0, 0, 0, 0, 3'd0, 0);
        applyStimulus(0, 0, 0, 0, 3'd0, 0);
        applyStimulus(0, 1, 1, 1, 3'd0, 1);
        checkField("done_hold_busy", {7'd0, busy}, 8'd0);

        $display("[TB] start together with in_valid in IDLE");
        keep = m_o[2];
        applyStimulus(0, 1, ~keep, 1, 3'd2, 1);
        checkField("start_prio_o2", {7'd0, o[2]}, {7'd0, keep});
        checkField("start_prio_busy", {7'd0, busy}, 8'd1);

        $display("[TB] reset in the middle of a scan");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 1, 3'd0, 0);
        applyStimulus(1, 1, 1, 1, 3'd0, 0);
        checkField("midreset_o", o, 8'h00);
        applyStimulus(0, 1, 1, 1, 3'd6, 0);
        checkField("post_reset_write", o, 8'h40);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(63) == 0, $urandom_range(7) != 0,
                          1'($urandom_range(1)), $urandom_range(3) != 0,
                          3'($urandom_range(7)), $urandom_range(15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/demux1_8_seq.md
Name: demux1_8_seq

Overview:
- Registered 1-to-8 demultiplexer/deserializer; the distribution-side counterpart of the team's 8:1 select mux.
- Takes one serial data bit plus a 3-bit select and steers it into one of eight registered output lanes.
- Also supports an auto-scan mode that collects 8 consecutive bits into a byte.
- Feeds per-lane flags and control bits in the game logic.

Parameters:
- RESET_VAL, 8'h00, value loaded into the output lanes on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- e  input  1  global enable; when low, no state changes occur.
- in  input  1  serial data bit.
- in_valid  input  1  data bit qualifier.
- sel  input  3  lane index, used in addressed mode.
- start  input  1  one-cycle request to begin an 8-bit auto-scan.
- o  output  8  registered lane outputs.
- stb  output  8  one-hot, one-cycle write strobe of the lane written this cycle.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when a scan's 8th bit has been written.
- idx  output  3  current scan lane index.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - o=RESET_VAL, stb=0, busy=0, done=0, idx=0, state=IDLE.
  - Reset overrides every other input, including mid-scan; a partial byte is discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If e & in_valid & !start: o[sel]<=in, stb<=(1<<sel), other lanes hold. Visible 1 cycle after the accepting edge.
  - If e & start: enter SCAN, idx<=0, busy<=1. A simultaneous in_valid is not written; start has priority.
  - Otherwise stb<=0.
- SCAN:
  - Each cycle with e & in_valid: o[idx]<=in, stb<=(1<<idx), idx<=idx+1.
  - sel is ignored in SCAN.
  - A cycle with in_valid=0 is a stall: idx holds, stb=0.
  - The write at idx=7 transitions to DONE, and idx wraps to 0.
  - start while in SCAN is ignored; there is no restart.
- DONE (one cycle):
  - done=1, busy=0, stb=0. Inputs are ignored this cycle.
  - Next state is IDLE. done is registered and coincides with the DONE state.
- e=0 in any state:
  - Freezes state, idx, and o.
  - Forces stb=0 on the next edge. done still deasserts if the machine was in DONE; the state then holds DONE until e returns.
- Latency:
  - Addressed mode: in → o is 1 cycle.
  - Auto-scan: start → first write needs at least 1 cycle after entering SCAN. The byte is complete 8 accepted bits later, and done follows in the next cycle.
- stb is always one-hot or zero; it is never multi-bit.

Optional Feature:
- Macro: SCAN_MSB_FIRST_EN.
- Defined:
  - Scan starts at idx=7 and decrements; the write at idx=0 ends the scan.
  - Reset and the post-scan idx value become 7.
- Not defined: LSB-first as described above, with reset/post-scan idx=0.
- Addressed mode is unaffected either way.

Test Plan:
- Reset then idle: assert reset for 2 cycles → o=8'h00, stb=0, busy=0, done=0, idx=0.
- Addressed write: e=1, in_valid=1, in=1, sel=5 → next cycle o=8'h20, stb=8'h20. Then sel=5, in=0 → o=8'h00. With e=0 and in_valid=1, o is unchanged.
- Auto-scan, LSB-first: start=1 for 1 cycle, then bits 1,0,1,1,0,0,1,0 with in_valid=1 → o=8'h4D, busy high for 8 write cycles, done pulse exactly 1 cycle after the 8th write, then IDLE.
- Stalls and enable: same scan with in_valid=0 for 3 cycles after bit 3 and e=0 for 2 cycles after bit 6 → idx holds during each gap, final o=8'h4D, done after the 8th accepted bit only.
- Start during scan, and start with in_valid in IDLE: start at bit 4 → ignored, byte completes normally. start with in_valid, sel=2 in IDLE → o[2] not written, SCAN entered.
- Reset mid-scan: reset after 4 bits → o=8'h00, busy=0, idx=0, no done pulse. A following addressed write works normally.
- With SCAN_MSB_FIRST_EN defined, repeat the auto-scan test → o=8'hB2.
